// File: rtl/bike_readout_pkg.sv
// Shared definitions for the sample BRAM readout block.
//   num_words()      : number of 32-bit BRAM words holding a sample string
//   addr_w()         : BRAM word-address width for a given sample length
//   last_word_mask() : keeps only the valid bits of the final word
//   state_t          : readout controller states
package bike_readout_pkg;

    localparam int WORD_W                = 32;
    localparam int DEFAULT_SAMPLE_LENGTH = 256;

    function automatic int num_words(input int sample_length);
        return (sample_length + WORD_W - 1) / WORD_W;
    endfunction

    function automatic int addr_w(input int sample_length);
        return $clog2(sample_length / WORD_W) + 1;
    endfunction

    // Address width for the default sample length.
    localparam int DEFAULT_ADDR_W = addr_w(DEFAULT_SAMPLE_LENGTH);

    // Bits above the sample length in the final word are unused storage and
    // must never reach the consumer.
    function automatic logic [WORD_W-1:0] last_word_mask(input int sample_length);
        logic [WORD_W-1:0] mask;
        int                rem;
        rem = sample_length % WORD_W;
        for (int b = 0; b < WORD_W; b++) begin
            mask[b] = (rem == 0) || (b < rem);
        end
        return mask;
    endfunction

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bike_fifo2.sv
// Two-entry synchronous FIFO that buffers BRAM words ahead of the output port.
//   clk, rst_n   : clock, synchronous active-low reset
//   push_i       : write push_data_i this cycle
//   push_data_i  : entry to store (data word plus last-word flag)
//   pop_i        : drop the head entry this cycle
//   head_o       : oldest entry
//   count_o      : occupancy, 0..2
module bike_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The upstream credit scheme must never overrun or underrun the buffer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_i && (count_q == 2'd2)));
            assert (!(pop_i && (count_q == 2'd0)));
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bike_sampler_readout.sv
// Streams a sampled bit string out of BRAM as 32-bit words over valid/ready.
//   CLK, RESETN            : clock, synchronous active-low reset
//   ENABLE                 : level start request, sampled while idle
//   DONE                   : high once the final word has been accepted
//   RDEN, ADDR, DIN        : BRAM read port (data one cycle after RDEN)
//   DOUT_VALID/READY       : output handshake
//   DOUT, DOUT_LAST        : output word (0 when not valid) and final-word flag
module bike_sampler_readout
    import bike_readout_pkg::*;
#(
    parameter int SAMPLE_LENGTH = 256
) (
    input  logic                             CLK,
    input  logic                             RESETN,
    input  logic                             ENABLE,
    output logic                             DONE,
    output logic                             RDEN,
    output logic [addr_w(SAMPLE_LENGTH)-1:0] ADDR,
    input  logic [31:0]                      DIN,
    output logic                             DOUT_VALID,
    input  logic                             DOUT_READY,
    output logic [31:0]                      DOUT,
    output logic                             DOUT_LAST
);

    localparam int                ADDR_W    = addr_w(SAMPLE_LENGTH);
    localparam int                NUM_WORDS = num_words(SAMPLE_LENGTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [WORD_W-1:0] LAST_MASK = last_word_mask(SAMPLE_LENGTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic                done_q, done_d;

    logic                rden;
    logic                pop;
    logic                credit_ok;
    logic                fifo_empty;
    logic [1:0]          occupancy;
    logic [WORD_W:0]     head;        // {last, data}
    logic [WORD_W:0]     push_entry;

    assign fifo_empty = (occupancy == 2'd0);
    assign pop        = !fifo_empty && DOUT_READY;

    // occupancy + inflight - pop < 2, rearranged to stay non-negative.
    // A read may only be issued if its data is guaranteed a free slot when
    // it returns next cycle.
    assign credit_ok = ({1'b0, occupancy} + {2'b00, inflight_q})
                       < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rden    = 1'b0;
        case (state_q)
            S_RESET: begin
                addr_d = '0;
                if (ENABLE) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    rden   = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The final word is the only thing left once it is popped.
                if (pop && head[WORD_W] && (occupancy == 2'd1) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!ENABLE) begin
                    state_d = S_RESET;
                end
            end
            default: state_d = S_RESET;
        endcase
        inflight_d      = rden;
        inflight_last_d = rden && (addr_q == LAST_ADDR);
        done_d          = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q         <= S_RESET;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // The final word is masked and tagged as it enters the buffer, so the
    // head entry is already in its outgoing form.
    assign push_entry = {inflight_last_q,
                         inflight_last_q ? (DIN & LAST_MASK) : DIN};

    bike_fifo2 #(
        .W(WORD_W + 1)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RESETN),
        .push_i      (inflight_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (occupancy)
    );

    assign RDEN       = rden;
    assign ADDR       = addr_q;
    assign DONE       = done_q;
    assign DOUT_VALID = !fifo_empty;
    assign DOUT       = fifo_empty ? '0 : head[WORD_W-1:0];
    assign DOUT_LAST  = !fifo_empty && head[WORD_W];

endmodule
